// File: rtl/mux_16x1_pkg.sv
// Shared types and the round-robin pick function for the 16-way lane arbiter.
package mux_16x1_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             any;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // Scanning from the far end and overwriting leaves the first hit at or after ptr.
  function automatic rr_pick_t rr_pick(input logic [N_CH-1:0]  req,
                                       input logic [SEL_W-1:0] ptr);
    rr_pick_t         res;
    logic [SEL_W-1:0] cand;
    // NOTE: every local gets a value before any conditional write, so no latch can be inferred.
    res  = '0;
    cand = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        res.any = 1'b1;
        res.idx = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_16x1.sv
// Plain 16:1 bit multiplexer; the arbiter drives its select.
module mux_16x1
  import mux_16x1_pkg::*;
(
  input  logic [N_CH-1:0]  in,
  input  logic [SEL_W-1:0] select,
  output logic             out
);

  assign out = in[select];

endmodule

// File: rtl/mux_16x1_rr_arbiter.sv
// Round-robin arbiter sharing one mux_16x1 lane among 16 requesters, with
// release on done, request withdrawal, or a hold-time limit.
module mux_16x1_rr_arbiter
  import mux_16x1_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic              done,
  input  logic [N_CH-1:0]   data_in,
  output logic [N_CH-1:0]   grant,
  output logic [SEL_W-1:0]  select,
  output logic              data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              timeout
);

  localparam int              HC_W      = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_MAX - 1);

  arb_state_t       state_q;
  logic [N_CH-1:0]  grant_q;
  logic [SEL_W-1:0] select_q;
  logic [SEL_W-1:0] ptr_q;
  logic [HC_W-1:0]  hold_cnt_q;
  logic             timeout_q;

  rr_pick_t pick;
  logic     hold_hit;
  logic     owner_req;
  logic     exit_grant;
  logic     mux_out;

  assign pick       = rr_pick(req, ptr_q);
  assign hold_hit   = (hold_cnt_q == HOLD_LAST);
  assign owner_req  = req[select_q];
  assign exit_grant = done | ~owner_req | hold_hit;

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      select_q   <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick.any) begin
            grant_q    <= N_CH'(1) << pick.idx;
            select_q   <= pick.idx;
            ptr_q      <= pick.idx + SEL_W'(1);
            hold_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt_q <= hold_cnt_q + HC_W'(1);
          if (exit_grant) begin
            grant_q   <= '0;
            // A timeout is flagged only when the hold limit was the sole cause.
            timeout_q <= hold_hit & ~done & owner_req;
            state_q   <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  mux_16x1 u_mux (
    .in     (data_in),
    .select (select_q),
    .out    (mux_out)
  );

  assign grant      = grant_q;
  assign select     = select_q;
  assign data_valid = (state_q == GRANT);
  assign busy       = (state_q != IDLE);
  assign timeout    = timeout_q;
  assign data_out   = mux_out & data_valid;

endmodule

// File: tb/tb_mux_16x1_rr_arbiter.sv
// Directed bench for mux_16x1_rr_arbiter: expected per-cycle outputs are queued
// when stimulus is applied and compared after the following rising edge.
module tb_mux_16x1_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [15:0] data_in;
  logic [15:0] grant;
  logic [3:0]  select;
  logic        data_out;
  logic        data_valid;
  logic        busy;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        dv;
    logic        dout;
    logic        to;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  mux_16x1_rr_arbiter #(.HOLD_MAX(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .data_in    (data_in),
    .grant      (grant),
    .select     (select),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input string field,
                     input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  // Queue the expectation, clock one edge, then pop and compare 1 ns later.
  task automatic cyc(input string tag, input logic [15:0] g, input logic [3:0] s,
                     input logic dv, input logic dout, input logic to, input logic bsy);
    exp_t e;
    e = '{grant: g, sel: s, dv: dv, dout: dout, to: to, busy: bsy};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(tag, "grant",      grant,           e.grant);
    chk(tag, "select",     16'(select),     16'(e.sel));
    chk(tag, "data_valid", 16'(data_valid), 16'(e.dv));
    chk(tag, "data_out",   16'(data_out),   16'(e.dout));
    chk(tag, "timeout",    16'(timeout),    16'(e.to));
    chk(tag, "busy",       16'(busy),       16'(e.busy));
  endtask

  // One-cycle award with done held high: GRANT, RELEASE, IDLE.
  task automatic award(input string tag, input int idx, input logic dout);
    cyc(tag, 16'(1) << idx, 4'(idx), 1'b1, dout, 1'b0, 1'b1);
    cyc(tag, 16'h0000,      4'(idx), 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(tag, 16'h0000,      4'(idx), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] pat [2];
    pat[0] = 16'hAAAA;
    pat[1] = 16'hF0F0;

    rst = 1'b1; req = '0; done = 1'b0; data_in = '0;
    cyc("reset", 16'h0000, 4'd0, 0, 0, 0, 0);
    cyc("reset", 16'h0000, 4'd0, 0, 0, 0, 0);
    rst = 1'b0;

    // Single requester runs to the hold limit.
    req = 16'h0010; data_in = 16'h0010;
    for (int i = 0; i < 8; i++) cyc("single_grant", 16'h0010, 4'd4, 1, 1, 0, 1);
    cyc("single_timeout", 16'h0000, 4'd4, 0, 0, 1, 1);
    req = '0;
    cyc("single_idle", 16'h0000, 4'd4, 0, 0, 0, 0);
    cyc("idle_hold",   16'h0000, 4'd4, 0, 0, 0, 0);

    // Fairness from a fresh pointer.
    rst = 1'b1;
    cyc("fair_reset", 16'h0000, 4'd0, 0, 0, 0, 0);
    rst = 1'b0;
    req = 16'hFFFF; done = 1'b1; data_in = '0;
    for (int k = 0; k < 17; k++) award("fair", k % 16, 1'b0);

    // Wrap-around after a grant to 14.
    req = 16'h4000;
    cyc("wrap_g14", 16'h4000, 4'd14, 1, 0, 0, 1);
    req = 16'h8003;
    cyc("wrap_rel14",  16'h0000, 4'd14, 0, 0, 0, 1);
    cyc("wrap_idle14", 16'h0000, 4'd14, 0, 0, 0, 0);
    award("wrap_15", 15, 1'b0);
    award("wrap_0",  0,  1'b0);
    award("wrap_1",  1,  1'b0);

    // Request drop on the hold-limit cycle is a normal release.
    req = 16'h0008; done = 1'b0;
    for (int i = 0; i < 8; i++) cyc("hold_grant", 16'h0008, 4'd3, 1, 0, 0, 1);
    req = '0;
    cyc("drop_release", 16'h0000, 4'd3, 0, 0, 0, 1);
    cyc("drop_idle",    16'h0000, 4'd3, 0, 0, 0, 0);

    // Data path through the mux, gated by data_valid.
    done = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int idx = 0; idx < 16; idx++) begin
        data_in = pat[p];
        req     = 16'(1) << idx;
        award("mux", idx, pat[p][idx]);
      end
    end

    // Reset in the third GRANT cycle.
    req = 16'h0020; done = 1'b0; data_in = 16'hFFFF;
    for (int i = 0; i < 3; i++) cyc("mid_grant", 16'h0020, 4'd5, 1, 1, 0, 1);
    rst = 1'b1;
    cyc("mid_reset", 16'h0000, 4'd0, 0, 0, 0, 0);
    rst = 1'b0;
    req = 16'h0041;
    cyc("post_reset_pick", 16'h0001, 4'd0, 1, 1, 0, 1);
    done = 1'b1;
    cyc("post_reset_rel",  16'h0000, 4'd0, 0, 0, 0, 1);
    req = '0;
    cyc("post_reset_idle", 16'h0000, 4'd0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_16x1_rr_arbiter.md
# mux_16x1_rr_arbiter

Round-robin arbiter that shares one `mux_16x1` output lane between 16 requesters. Each requester raises `req[i]` to own the lane. The arbiter grants one requester at a time, drives the mux `select`, and qualifies the muxed bit with `data_valid`. A grant ends on `done`, on request withdrawal, or on a hold-time limit, so one requester cannot starve the others.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum cycles a grant may stay in GRANT before forced release. Legal range 1..256.

Ports:
- `clk`  in  1  — the single clock. All state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req`  in  16  — per-requester lane request. Level-sensitive.
- `done`  in  1  — current owner finished. Sampled only in GRANT.
- `data_in`  in  16  — per-requester data bit. Feeds the `mux_16x1` `in` port.
- `grant`  out  16  — one-hot owner. All zeros when no owner.
- `select`  out  4  — mux select. Registered; equals the index of the current or last owner.
- `data_out`  out  1  — `data_in[select]` while `data_valid` is 1, otherwise 0.
- `data_valid`  out  1  — high exactly while in GRANT.
- `busy`  out  1  — high when the state is not IDLE.
- `timeout`  out  1  — one-cycle pulse in RELEASE when the grant ended on the hold limit.

## Operation
- States are IDLE, GRANT and RELEASE.
- `ptr` (4 bits) is the highest-priority index. The winner is the first set bit of `req` scanning `ptr`, `ptr+1`, … wrapping 15→0.
- IDLE, with any `req` bit set:
  - register `grant` = one-hot(winner) and `select` = winner;
  - set `ptr` = winner+1 mod 16;
  - clear `hold_cnt`;
  - go to GRANT.
- IDLE, with `req` = 0: stay in IDLE. All outputs hold, `grant` stays 0.
- GRANT:
  - `hold_cnt` increments each cycle;
  - exit to RELEASE when any of these is true at the edge: `done`=1, `req[select]`=0, or `hold_cnt`=HOLD_MAX-1;
  - changes on other `req` bits are ignored while in GRANT.
- RELEASE:
  - `grant`=0, `data_valid`=0, `select` holds;
  - `timeout`=1 only if the exit cause was the hold limit alone;
  - always go to IDLE next cycle.
- Simultaneous exit causes: if `done` or request drop coincides with the hold limit, the exit is a normal release and `timeout`=0.
- A requester released on timeout that still holds `req` has lowest priority in the next arbitration, because `ptr` has already moved past it.
- Reset values: state=IDLE, `grant`=0, `select`=0, `ptr`=0, `hold_cnt`=0, `busy`=0, `data_valid`=0, `timeout`=0, `data_out`=0.
- `rst` asserted mid-GRANT drops `grant` on the next edge with no RELEASE cycle and no `timeout` pulse.
- Width rules:
  - `hold_cnt` width is `$clog2(HOLD_MAX)`, minimum 1 bit;
  - HOLD_MAX=1 gives exactly one GRANT cycle per award;
  - `ptr` and the winner index wrap modulo 16 with no extra logic.

## Timing
- Request to grant: `req[i]` sampled high in IDLE at edge k, so `grant[i]`, `select`=i and `data_valid` are visible after edge k.
- `data_out` is combinational from `data_in` through the `mux_16x1` instance and the `data_valid` gate. There is no register on the data path.
- Grant length: 1..HOLD_MAX cycles.
- Gap between consecutive grants: 2 cycles with `data_valid` low (RELEASE, then IDLE arbitration).
- Peak lane utilisation: HOLD_MAX/(HOLD_MAX+2).
- `done` is registered into the state transition, so `data_valid` falls the edge after `done` is sampled high.

## Structure
- Package `mux_16x1_pkg`:
  - `N_CH`=16 and `SEL_W`=4;
  - state enum `arb_state_t` {IDLE, GRANT, RELEASE};
  - pure function `rr_pick(req, ptr)`, which returns the winner index and an any-request flag.
- Sub-module: one instance of the existing `mux_16x1`, with `.in(data_in)`, `.select(select)` and `.out` feeding the `data_valid` gate.
- Arbitration logic, counter and FSM stay in this module.

## Test plan
- Reset then single requester:
  - hold `rst` 2 cycles, then `req`=16'h0010 and `data_in`=16'h0010 with `done` low;
  - `grant`=16'h0010 and `select`=4 one cycle later;
  - `data_out`=1 for 8 cycles, then `timeout` pulses once.
- Fairness:
  - hold `req`=16'hFFFF with `done` high every GRANT cycle;
  - grant order is 0,1,2,…,15,0;
  - each grant is 1 cycle, with a 2-cycle gap between grants.
- Wrap-around:
  - after a grant to requester 14, set `req`=16'h0003 | 16'h8000;
  - the next grant goes to 15, then 0, then 1.
- Withdrawal and simultaneity:
  - drop `req[3]` in the same cycle as the hold limit;
  - the arbiter enters RELEASE and `timeout` stays 0.
- Data mux check:
  - `data_in`=16'hAAAA, then 16'hF0F0, with each index granted in turn;
  - `data_out` equals bit `select` of the pattern while `data_valid` is high, and is 0 otherwise.
- Reset mid-grant:
  - assert `rst` in the 3rd GRANT cycle;
  - all outputs are at their reset values after that edge, and `ptr`=0 so `req[0]` wins next.
